float_adder_pipe_cal_c2n: RTL and testbench
===========================================

Name: float_adder_pipe_cal_c2n

Overview:
- Calculation stage of the pipelined single-precision float adder.
- Consumes the aligned operands held in the align-to-calc register and performs the fraction add or subtract.
- Registers the result, with pass-through fields, into the calc-to-normalize register that feeds the normalization/rounding stage.
- Adds valid tracking, stall (en) and flush, so the stage can sit under the CPU pipeline's hazard control.

Parameters:
- none (widths fixed by IEEE-754 single precision: 24-bit large fraction, 27-bit small fraction with guard/round/sticky, 28-bit result)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  stage enable; 0 = stall, output registers hold
- flush  in  1  kill the in-flight result; clears n_valid
- c_valid  in  1  calc-stage inputs hold a real operation
- c_rm  in  2  rounding mode (00 nearest, 01 zero, 10 +inf, 11 -inf)
- c_inf_nan  in  1  result is inf/NaN (special case)
- c_inf_nan_frac  in  23  fraction to emit for inf/NaN
- c_sign  in  1  result sign from the align stage
- c_exp  in  8  larger exponent
- c_op_sub  in  1  1 = effective subtraction
- c_large_frac  in  24  larger operand fraction with hidden bit
- c_small_frac  in  27  shifted smaller fraction, 3 low guard/round/sticky bits
- n_valid  out  1  output registers hold a valid result
- n_rm  out  2  registered c_rm
- n_inf_nan  out  1  registered c_inf_nan
- n_inf_nan_frac  out  23  registered c_inf_nan_frac
- n_sign  out  1  registered result sign
- n_exp  out  8  registered c_exp
- n_cal_frac  out  28  registered add/sub result
- n_zero  out  1  registered flag: cal_frac == 0

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, including n_valid, n_cal_frac = 28'h0 and n_rm = 2'b00.
- Arithmetic (combinational, inside the block):
  - large_ext = {1'b0, c_large_frac, 3'b000}
  - small_ext = {1'b0, c_small_frac}
  - cal_frac = c_op_sub ? large_ext - small_ext : large_ext + small_ext, truncated to 28 bits.
  - Subtraction never underflows because the align stage guarantees large >= small. Bit 27 is the addition carry-out.
- zero = (cal_frac == 28'h0).
- Latency: exactly 1 clk from inputs to n_*.
- Update priority on each rising edge:
  1. flush = 1: n_valid <= 0. Data registers load as in the en rule below when en = 1, otherwise hold. flush wins over en and c_valid.
  2. else en = 1: all n_* load; n_valid <= c_valid.
  3. else (en = 0): all n_* hold, including n_valid.
- Data registers load whenever en = 1, regardless of c_valid. Downstream must qualify with n_valid.
- Inf/NaN path: arithmetic still computes, and n_inf_nan/n_inf_nan_frac pass through unchanged. Normalization selects on n_inf_nan.
- Reset asserted mid-operation: immediate clear, in-flight result discarded, no partial update.
- Simultaneous en = 0 and flush = 1: n_valid clears, data holds.

Optional Feature:
- Macro: FADD_CAL_ZERO_SIGN_EN
- Defined: when c_op_sub = 1, zero = 1 and c_inf_nan = 0, the registered n_sign = (c_rm == 2'b11), giving IEEE exact-zero signing (-0 only when rounding toward -inf). Otherwise n_sign = c_sign.
- Undefined: n_sign = c_sign always. The normalization stage owns zero-sign fix-up.

Test Plan:
- Reset: drive rst_n low with random inputs -> all outputs 0, n_valid = 0; release, first en edge loads.
- Add 1.0 + 1.0: c_large_frac = 24'h800000, c_small_frac = 27'h4000000, c_op_sub = 0, c_valid = 1, en = 1 -> next cycle n_cal_frac = 28'h8000000, n_zero = 0, n_valid = 1, n_exp = c_exp.
- Sub 1.5 - 0.5: 24'hC00000 and 27'h2000000, c_op_sub = 1 -> n_cal_frac = 28'h4000000. Sub equal: 24'h800000 and 27'h4000000 -> n_cal_frac = 0, n_zero = 1. With the macro, c_rm = 2'b11 gives n_sign = 1 and c_rm = 2'b00 gives n_sign = 0.
- Stall: load a result, then en = 0 for 3 cycles while inputs change -> all n_* unchanged; en = 1 -> new values appear next edge.
- Flush: n_valid = 1, assert flush with en = 1 and c_valid = 1 -> n_valid = 0 next cycle. Flush with en = 0 -> n_valid = 0, n_cal_frac unchanged.
- Inf/NaN pass-through: c_inf_nan = 1, c_inf_nan_frac = 23'h400000 -> n_inf_nan = 1, n_inf_nan_frac = 23'h400000, n_sign = c_sign even with the macro defined.

Source files
------------

// File: rtl/float_adder_pipe_cal_c2n.sv
// Calculation stage of the pipelined float adder: fraction add/sub into the calc-to-normalize register.
// Latency: 1 clk from c_* inputs to n_* outputs.
// Backpressure: en=0 stalls (all n_* hold); flush clears n_valid only. Option macro: FADD_CAL_ZERO_SIGN_EN.
module float_adder_pipe_cal_c2n (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        flush,
  input  logic        c_valid,
  input  logic [1:0]  c_rm,
  input  logic        c_inf_nan,
  input  logic [22:0] c_inf_nan_frac,
  input  logic        c_sign,
  input  logic [7:0]  c_exp,
  input  logic        c_op_sub,
  input  logic [23:0] c_large_frac,
  input  logic [26:0] c_small_frac,
  output logic        n_valid,
  output logic [1:0]  n_rm,
  output logic        n_inf_nan,
  output logic [22:0] n_inf_nan_frac,
  output logic        n_sign,
  output logic [7:0]  n_exp,
  output logic [27:0] n_cal_frac,
  output logic        n_zero
);

  logic [27:0] large_ext;
  logic [27:0] small_ext;
  logic [27:0] cal_frac;
  logic        zero;
  logic        sign_nxt;

  // Large fraction gets three zero guard/round/sticky bits; bit 27 catches the add carry-out.
  assign large_ext = {1'b0, c_large_frac, 3'b000};
  assign small_ext = {1'b0, c_small_frac};

  // Align stage guarantees large >= small, so subtraction never wraps.
  assign cal_frac = c_op_sub ? (large_ext - small_ext) : (large_ext + small_ext);
  assign zero     = (cal_frac == 28'h0);

  // Result sign: optionally force IEEE exact-zero sign on an effective subtraction that cancels.
  always_comb begin
    sign_nxt = c_sign;
`ifdef FADD_CAL_ZERO_SIGN_EN
    if (c_op_sub && zero && !c_inf_nan) begin
      sign_nxt = (c_rm == 2'b11);
    end
`endif
  end

  // Valid tracking: flush kills the in-flight result even while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_valid <= 1'b0;
    end else if (flush) begin
      n_valid <= 1'b0;
    end else if (en) begin
      n_valid <= c_valid;
    end
  end

  // Data registers load on every enabled edge; consumers qualify with n_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_rm           <= 2'b00;
      n_inf_nan      <= 1'b0;
      n_inf_nan_frac <= 23'h0;
      n_sign         <= 1'b0;
      n_exp          <= 8'h0;
      n_cal_frac     <= 28'h0;
      n_zero         <= 1'b0;
    end else if (en) begin
      n_rm           <= c_rm;
      n_inf_nan      <= c_inf_nan;
      n_inf_nan_frac <= c_inf_nan_frac;
      n_sign         <= sign_nxt;
      n_exp          <= c_exp;
      n_cal_frac     <= cal_frac;
      n_zero         <= zero;
    end
  end

endmodule

// File: tb/tb_float_adder_pipe_cal_c2n.sv
// Bench for the float adder calculation stage: directed cases plus randomized traffic.
// Reference model computes fractions with plain integer arithmetic and tracks register state.
// Stall, flush and asynchronous reset are exercised both directed and at random.
module tb_float_adder_pipe_cal_c2n;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic        c_valid;
  logic [1:0]  c_rm;
  logic        c_inf_nan;
  logic [22:0] c_inf_nan_frac;
  logic        c_sign;
  logic [7:0]  c_exp;
  logic        c_op_sub;
  logic [23:0] c_large_frac;
  logic [26:0] c_small_frac;
  logic        n_valid;
  logic [1:0]  n_rm;
  logic        n_inf_nan;
  logic [22:0] n_inf_nan_frac;
  logic        n_sign;
  logic [7:0]  n_exp;
  logic [27:0] n_cal_frac;
  logic        n_zero;

  int checks;
  int failures;

  // reference model state
  logic        m_valid;
  logic [1:0]  m_rm;
  logic        m_inf_nan;
  logic [22:0] m_inf_nan_frac;
  logic        m_sign;
  logic [7:0]  m_exp;
  logic [27:0] m_frac;
  logic        m_zero;

  logic [64:0] obs;
  logic [64:0] expv;
  assign obs  = {n_valid, n_rm, n_inf_nan, n_inf_nan_frac, n_sign, n_exp, n_cal_frac, n_zero};
  assign expv = {m_valid, m_rm, m_inf_nan, m_inf_nan_frac, m_sign, m_exp, m_frac, m_zero};

  float_adder_pipe_cal_c2n dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .c_valid(c_valid),
    .c_rm(c_rm), .c_inf_nan(c_inf_nan), .c_inf_nan_frac(c_inf_nan_frac),
    .c_sign(c_sign), .c_exp(c_exp), .c_op_sub(c_op_sub),
    .c_large_frac(c_large_frac), .c_small_frac(c_small_frac),
    .n_valid(n_valid), .n_rm(n_rm), .n_inf_nan(n_inf_nan),
    .n_inf_nan_frac(n_inf_nan_frac), .n_sign(n_sign), .n_exp(n_exp),
    .n_cal_frac(n_cal_frac), .n_zero(n_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid = 0; m_rm = 0; m_inf_nan = 0; m_inf_nan_frac = 0;
    m_sign = 0; m_exp = 0; m_frac = 0; m_zero = 0;
  endtask

  // Spec-level behaviour: fraction value = large * 8 +/- small, modulo 2^28.
  task automatic model_edge();
    longint lv, sv, rv;
    logic [63:0] r64;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (flush) m_valid = 0;
    else if (en) m_valid = c_valid;
    if (en) begin
      lv = longint'(c_large_frac) * 8;
      sv = longint'(c_small_frac);
      rv = c_op_sub ? (lv - sv) : (lv + sv);
      r64 = rv;
      m_frac = r64[27:0];
      m_zero = (m_frac == 0);
      m_rm = c_rm;
      m_inf_nan = c_inf_nan;
      m_inf_nan_frac = c_inf_nan_frac;
      m_exp = c_exp;
      m_sign = c_sign;
`ifdef FADD_CAL_ZERO_SIGN_EN
      if (c_op_sub && m_zero && !c_inf_nan) m_sign = (c_rm == 2'b11);
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_ops(input logic v, input logic [1:0] rm, input logic inf,
                         input logic [22:0] inff, input logic s, input logic [7:0] e,
                         input logic sub, input logic [23:0] lf, input logic [26:0] sf);
    c_valid = v; c_rm = rm; c_inf_nan = inf; c_inf_nan_frac = inff;
    c_sign = s; c_exp = e; c_op_sub = sub; c_large_frac = lf; c_small_frac = sf;
  endtask

  task automatic randomize_ops();
    logic [23:0] lf;
    logic [26:0] sf;
    logic sub;
    lf  = {1'b1, 23'($urandom)};
    if ($urandom_range(0, 7) == 0) lf = 24'($urandom);
    sub = 1'($urandom);
    if (sub) begin
      if ($urandom_range(0, 5) == 0) sf = {lf, 3'b000};
      else sf = 27'($urandom_range(0, int'({lf, 3'b000})));
    end else begin
      sf = 27'($urandom);
    end
    set_ops(1'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0), 23'($urandom),
            1'($urandom), 8'($urandom), sub, lf, sf);
  endtask

  task automatic test_reset();
    rst_n = 0; en = 1; flush = 0;
    randomize_ops();
    c_valid = 1;
    model_reset();
    @(posedge clk); #1;
    randomize_ops();
    @(posedge clk); #1;
    checks++;
    if (obs !== 65'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 65'h0);
    end
    checks++;
    if (n_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %b expected 0", n_valid);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_add();
    en = 1; flush = 0;
    set_ops(1, 2'b00, 0, 23'h0, 0, 8'h7F, 0, 24'h800000, 27'h4000000);
    tick();
    checks++;
    if (n_cal_frac !== 28'h8000000 || n_zero !== 1'b0 || n_valid !== 1'b1 || n_exp !== 8'h7F) begin
      failures++;
      $display("FAIL add_1p0_1p0: got frac=%h zero=%b valid=%b exp=%h expected frac=8000000 zero=0 valid=1 exp=7f",
               n_cal_frac, n_zero, n_valid, n_exp);
    end
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL add_model: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_sub();
    set_ops(1, 2'b01, 0, 23'h0, 1, 8'h80, 1, 24'hC00000, 27'h2000000);
    tick();
    checks++;
    if (n_cal_frac !== 28'h4000000 || n_zero !== 1'b0 || n_sign !== 1'b1) begin
      failures++;
      $display("FAIL sub_1p5_0p5: got frac=%h zero=%b sign=%b expected frac=4000000 zero=0 sign=1",
               n_cal_frac, n_zero, n_sign);
    end
    // equal operands, round toward -inf, input sign 0
    set_ops(1, 2'b11, 0, 23'h0, 0, 8'h80, 1, 24'h800000, 27'h4000000);
    tick();
    checks++;
    if (n_cal_frac !== 28'h0 || n_zero !== 1'b1) begin
      failures++;
      $display("FAIL sub_equal: got frac=%h zero=%b expected frac=0 zero=1", n_cal_frac, n_zero);
    end
    checks++;
`ifdef FADD_CAL_ZERO_SIGN_EN
    if (n_sign !== 1'b1) begin
      failures++;
      $display("FAIL zero_sign_rm11: got %b expected 1", n_sign);
    end
`else
    if (n_sign !== 1'b0) begin
      failures++;
      $display("FAIL zero_sign_rm11: got %b expected 0", n_sign);
    end
`endif
    // equal operands, round to nearest, input sign 1
    set_ops(1, 2'b00, 0, 23'h0, 1, 8'h80, 1, 24'h800000, 27'h4000000);
    tick();
    checks++;
`ifdef FADD_CAL_ZERO_SIGN_EN
    if (n_sign !== 1'b0) begin
      failures++;
      $display("FAIL zero_sign_rm00: got %b expected 0", n_sign);
    end
`else
    if (n_sign !== 1'b1) begin
      failures++;
      $display("FAIL zero_sign_rm00: got %b expected 1", n_sign);
    end
`endif
  endtask

  task automatic test_stall();
    set_ops(1, 2'b10, 0, 23'h0, 0, 8'h81, 0, 24'hA00000, 27'h1000000);
    tick();
    // expected 0xA00000*8 + 0x1000000 = 0x6000000
    en = 0;
    for (int i = 0; i < 3; i++) begin
      randomize_ops();
      tick();
      checks++;
      if (n_cal_frac !== 28'h6000000 || n_exp !== 8'h81 || n_valid !== 1'b1 || n_rm !== 2'b10) begin
        failures++;
        $display("FAIL stall_hold: got frac=%h exp=%h valid=%b rm=%b expected frac=6000000 exp=81 valid=1 rm=10",
                 n_cal_frac, n_exp, n_valid, n_rm);
      end
    end
    en = 1;
    set_ops(1, 2'b00, 0, 23'h0, 0, 8'h90, 0, 24'h800000, 27'h0000008);
    tick();
    checks++;
    if (n_cal_frac !== 28'h4000008 || n_exp !== 8'h90) begin
      failures++;
      $display("FAIL stall_release: got frac=%h exp=%h expected frac=4000008 exp=90", n_cal_frac, n_exp);
    end
  endtask

  task automatic test_flush();
    en = 1; flush = 1;
    set_ops(1, 2'b00, 0, 23'h0, 0, 8'h91, 0, 24'h800000, 27'h0000010);
    tick();
    flush = 0;
    checks++;
    if (n_valid !== 1'b0 || n_cal_frac !== 28'h4000010) begin
      failures++;
      $display("FAIL flush_en: got valid=%b frac=%h expected valid=0 frac=4000010", n_valid, n_cal_frac);
    end
    tick();
    en = 0; flush = 1;
    randomize_ops();
    tick();
    checks++;
    if (n_valid !== 1'b0 || n_cal_frac !== 28'h4000010 || n_exp !== 8'h91) begin
      failures++;
      $display("FAIL flush_stall: got valid=%b frac=%h exp=%h expected valid=0 frac=4000010 exp=91",
               n_valid, n_cal_frac, n_exp);
    end
    flush = 0; en = 1;
  endtask

  task automatic test_inf_nan();
    set_ops(1, 2'b11, 1, 23'h400000, 0, 8'hFF, 1, 24'h800000, 27'h4000000);
    tick();
    checks++;
    if (n_inf_nan !== 1'b1 || n_inf_nan_frac !== 23'h400000 || n_sign !== 1'b0 || n_zero !== 1'b1) begin
      failures++;
      $display("FAIL inf_nan_pass: got inf=%b frac=%h sign=%b zero=%b expected inf=1 frac=400000 sign=0 zero=1",
               n_inf_nan, n_inf_nan_frac, n_sign, n_zero);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      randomize_ops();
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (obs !== 65'h0) begin
          failures++;
          $display("FAIL async_reset: got %h expected 0", obs);
        end
        #1 rst_n = 1;
      end
      tick();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL random_%0d: got %h expected %h", i, obs, expv);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    test_reset();
    test_add();
    test_sub();
    test_stall();
    test_flush();
    test_inf_nan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
